// File: rtl/crc_serial_param.sv
// Bit-serial CRC generator: accumulates a message one bit per clock, then shifts the CRC out LSB first.
// Optional parallel result port enabled by defining CRC_PAR_OUT_EN.
module crc_serial_param #(
    parameter int unsigned CRC_WIDTH = 8,
    parameter logic [31:0] POLY      = 8'h07,
    parameter logic [31:0] SEED      = 8'hD8,
    parameter logic [31:0] XOR_OUT   = 8'h00
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ACTIVE,
    input  logic                 DATA,
    output logic                 CRC,
    output logic                 VALID,
    output logic                 READY,
`ifdef CRC_PAR_OUT_EN
    output logic [CRC_WIDTH-1:0] CRC_PAR,
    output logic                 CRC_PAR_VLD,
`endif
    output logic [1:0]           DBG_STATE
);

    localparam int unsigned W  = CRC_WIDTH;
    localparam int unsigned CW = $clog2(CRC_WIDTH) + 1;
    localparam logic [W-1:0]  P_POLY   = POLY[W-1:0];
    localparam logic [W-1:0]  P_SEED   = SEED[W-1:0];
    localparam logic [W-1:0]  P_XOR    = XOR_OUT[W-1:0];
    localparam logic [CW-1:0] CNT_LAST = CW'(CRC_WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (CRC_WIDTH < 2 || CRC_WIDTH > 32) begin : g_bad_width
        $error("crc_serial_param: CRC_WIDTH must be in 2..32");
    end
    if ((POLY >> CRC_WIDTH) != 32'd0 || (SEED >> CRC_WIDTH) != 32'd0 ||
        (XOR_OUT >> CRC_WIDTH) != 32'd0) begin : g_bad_param
        $error("crc_serial_param: POLY, SEED and XOR_OUT must fit in CRC_WIDTH bits");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [W-1:0]    r_crc;
    logic [W-1:0]    w_crc_next;
    logic [W-1:0]    r_shift;
    logic [W-1:0]    w_shift_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic            w_par_load;

    function automatic logic [W-1:0] crc_step(input logic [W-1:0] r, input logic d);
        logic fb;
        fb = d ^ r[W-1];
        return {r[W-2:0], 1'b0} ^ (fb ? P_POLY : '0);
    endfunction

    always_comb begin
        w_state_next = r_state;
        w_crc_next   = r_crc;
        w_shift_next = r_shift;
        w_cnt_next   = r_cnt;
        w_par_load   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // The first message bit is consumed on the edge that first sees ACTIVE.
                if (ACTIVE) begin
                    w_crc_next   = crc_step(P_SEED, DATA);
                    w_state_next = S_ACCUM;
                end else begin
                    w_crc_next = P_SEED;
                end
            end
            S_ACCUM: begin
                if (ACTIVE) begin
                    w_crc_next = crc_step(r_crc, DATA);
                end else begin
                    w_shift_next = r_crc ^ P_XOR;
                    w_cnt_next   = '0;
                    w_par_load   = 1'b1;
                    w_state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_shift_next = r_shift >> 1;
                w_cnt_next   = r_cnt + CNT_ONE;
                if (r_cnt == CNT_LAST) begin
                    w_crc_next   = P_SEED;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_crc_next   = P_SEED;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_crc   <= P_SEED;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_crc   <= w_crc_next;
            r_shift <= w_shift_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Outputs decode only registered state; ACTIVE/DATA never reach them combinationally.
    assign VALID     = (r_state == S_FLUSH);
    assign READY     = (r_state != S_FLUSH);
    assign CRC       = VALID & r_shift[0];
    assign DBG_STATE = r_state;

`ifdef CRC_PAR_OUT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            CRC_PAR     <= '0;
            CRC_PAR_VLD <= 1'b0;
        end else begin
            CRC_PAR_VLD <= w_par_load;
            if (w_par_load) begin
                CRC_PAR <= r_crc ^ P_XOR;
            end
        end
    end
`endif

endmodule

// File: tb/tb_crc_serial_param.sv
// Bench for crc_serial_param: four parameterisations share one stimulus stream and are
// checked every cycle against a message-level CRC model.
module tb_crc_serial_param;

    localparam int NI = 4;
    localparam int          P_W    [NI] = '{8, 8, 8, 16};
    localparam logic [31:0] P_POLY [NI] = '{32'h07, 32'h07, 32'h07, 32'h1021};
    localparam logic [31:0] P_SEED [NI] = '{32'hD8, 32'h00, 32'hD8, 32'h0000};
    localparam logic [31:0] P_XOR  [NI] = '{32'h00, 32'h00, 32'hFF, 32'h0000};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic active = 1'b0;
    logic data = 1'b0;
    logic [NI-1:0] crc_w;
    logic [NI-1:0] valid_w;
    logic [NI-1:0] ready_w;
    logic [31:0]   par_ext [NI];
    logic [NI-1:0] par_vld_w;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [1:0] dbg;
`ifdef CRC_PAR_OUT_EN
        logic [P_W[g]-1:0] par;
        logic              par_vld;
        assign par_ext[g]   = 32'(par);
        assign par_vld_w[g] = par_vld;
`else
        assign par_ext[g]   = 32'd0;
        assign par_vld_w[g] = 1'b0;
`endif
        crc_serial_param #(
            .CRC_WIDTH(P_W[g]),
            .POLY     (P_POLY[g]),
            .SEED     (P_SEED[g]),
            .XOR_OUT  (P_XOR[g])
        ) u_dut (
            .CLK        (clk),
            .RST        (rst),
            .ACTIVE     (active),
            .DATA       (data),
            .CRC        (crc_w[g]),
            .VALID      (valid_w[g]),
            .READY      (ready_w[g]),
`ifdef CRC_PAR_OUT_EN
            .CRC_PAR    (par),
            .CRC_PAR_VLD(par_vld),
`endif
            .DBG_STATE  (dbg)
        );
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // CRC of the first n bits of msg (bit 0 sent first), straight from the step rule.
    function automatic logic [31:0] crc_ref(input int w, input logic [31:0] poly,
                                            input logic [31:0] seed, input logic [1023:0] msg,
                                            input int n);
        logic [31:0] r, mask;
        logic fb;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        r = seed;
        for (int k = 0; k < n; k++) begin
            fb = msg[k] ^ r[w-1];
            r = ((r << 1) & mask) ^ (fb ? poly : 32'h0);
        end
        return r;
    endfunction

    // Message-level model: collected bits, then a W-bit flush of the finished value.
    logic [1023:0] m_vec   [NI];
    int            m_len   [NI];
    int            f_left  [NI];
    logic [31:0]   f_val   [NI];
    logic [31:0]   exp_par [NI];
    bit            exp_pv  [NI];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            exp_pv[i] = 1'b0;
            if (rst) begin
                m_len[i] = 0; f_left[i] = 0; f_val[i] = 0; exp_par[i] = 0;
            end else if (f_left[i] > 0) begin
                f_left[i]--;
            end else if (active) begin
                if (m_len[i] < 1024) begin
                    m_vec[i][m_len[i]] = data;
                    m_len[i]++;
                end
            end else if (m_len[i] > 0) begin
                f_val[i]   = crc_ref(P_W[i], P_POLY[i], P_SEED[i], m_vec[i], m_len[i]) ^ P_XOR[i];
                f_left[i]  = P_W[i];
                m_len[i]   = 0;
                exp_par[i] = f_val[i];
                exp_pv[i]  = 1'b1;
            end
        end
    end

    // Per-cycle compare plus a collector that reassembles each serial CRC.
    logic [31:0] col_val  [NI];
    int          col_idx  [NI];
    logic [31:0] last_crc [NI];
    int          done_cnt [NI];

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("u%0d_valid", i), 32'(valid_w[i]), 32'(f_left[i] > 0));
                chk($sformatf("u%0d_ready", i), 32'(ready_w[i]), 32'(f_left[i] == 0));
                if (f_left[i] > 0)
                    chk($sformatf("u%0d_crc_bit", i), 32'(crc_w[i]),
                        32'(f_val[i][P_W[i] - f_left[i]]));
`ifdef CRC_PAR_OUT_EN
                chk($sformatf("u%0d_par_vld", i), 32'(par_vld_w[i]), 32'(exp_pv[i]));
                chk($sformatf("u%0d_par", i), par_ext[i], exp_par[i]);
`endif
                if (valid_w[i] === 1'b1) begin
                    col_val[i] = col_val[i] | (32'(crc_w[i]) << col_idx[i]);
                    col_idx[i]++;
                    if (col_idx[i] == P_W[i]) begin
                        last_crc[i] = col_val[i];
                        done_cnt[i]++;
                        col_idx[i] = 0;
                        col_val[i] = 0;
                    end
                end else begin
                    col_idx[i] = 0;
                    col_val[i] = 0;
                end
            end
        end
    end

    task automatic drive(input logic a, input logic d);
        @(negedge clk);
        active = a;
        data   = d;
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        for (int k = 0; k < n; k++) drive(1'b1, v[k]);
        drive(1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0);
    endtask

    task automatic pulse_reset;
        @(negedge clk);
        rst = 1'b1; active = 1'b0; data = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_u%0d_valid", i), 32'(valid_w[i]), 32'd0);
            chk($sformatf("rst_u%0d_ready", i), 32'(ready_w[i]), 32'd1);
            chk($sformatf("rst_u%0d_crc", i), 32'(crc_w[i]), 32'd0);
        end
    endtask

    initial begin
        int b0, b1, low_cnt;
        for (int i = 0; i < NI; i++) begin
            col_val[i] = 0; col_idx[i] = 0; last_crc[i] = 0; done_cnt[i] = 0;
        end
        // Pin the reference model to hand-derived values.
        chk("ref_zero_byte", crc_ref(8, 32'h07, 32'hD8, 1024'd0, 8), 32'h06);
        chk("ref_byte01_w8", crc_ref(8, 32'h07, 32'h00, 1024'd1, 8), 32'h89);
        chk("ref_byte01_w16", crc_ref(16, 32'h1021, 32'h0, 1024'd1, 8), 32'h9188);

        @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset_u%0d_valid", i), 32'(valid_w[i]), 32'd0);
            chk($sformatf("reset_u%0d_ready", i), 32'(ready_w[i]), 32'd1);
            chk($sformatf("reset_u%0d_crc", i), 32'(crc_w[i]), 32'd0);
        end
        idle(2);

        // Zero byte on the default, zero-seed and XOR_OUT=FF builds.
        b0 = done_cnt[0];
        send_bits(64'h00, 8);
        idle(20);
        chk("t1_done", 32'(done_cnt[0]), 32'(b0 + 1));
        chk("t1_crc_default", last_crc[0], 32'h06);
        chk("t1_crc_seed0", last_crc[1], 32'h00);
        chk("t1_crc_xorff", last_crc[2], 32'hF9);
`ifdef CRC_PAR_OUT_EN
        chk("t6_par_default", par_ext[0], 32'h06);
`endif

        // Byte 0x01 LSB first; READY low for exactly 16 cycles on the 16-bit build.
        send_bits(64'h01, 8);
        low_cnt = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            #1;
            if (ready_w[3] === 1'b0) low_cnt++;
        end
        chk("t3_ready_low_w16", 32'(low_cnt), 32'd16);
        chk("t2_crc_seed0", last_crc[1], 32'h89);
        chk("t3_crc_w16", last_crc[3], 32'h9188);

        // ACTIVE during flush is dropped.
        b0 = done_cnt[0];
        for (int k = 0; k < 8; k++) drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        for (int k = 0; k < 6; k++) drive(1'b1, 1'b1);
        idle(24);
        chk("t4_single_flush", 32'(done_cnt[0]), 32'(b0 + 1));
        chk("t4_crc", last_crc[0], 32'h06);
        send_bits(64'h00, 8);
        idle(20);
        chk("t4_next_done", 32'(done_cnt[0]), 32'(b0 + 2));
        chk("t4_next_crc", last_crc[0], 32'h06);

        // Reset mid-message and mid-flush: nothing emitted, clean message afterwards.
        b0 = done_cnt[0];
        b1 = done_cnt[3];
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b0);
        pulse_reset();
        idle(20);
        chk("t5_msg_abort", 32'(done_cnt[0]), 32'(b0));
        send_bits(64'h00, 8);
        idle(3);
        pulse_reset();
        idle(20);
        chk("t5_flush_abort", 32'(done_cnt[0]), 32'(b0));
        chk("t5_flush_abort_w16", 32'(done_cnt[3]), 32'(b1));
        send_bits(64'h00, 8);
        idle(20);
        chk("t5_clean_done", 32'(done_cnt[0]), 32'(b0 + 1));
        chk("t5_clean_crc", last_crc[0], 32'h06);

        // Single-bit message.
        send_bits(64'h01, 1);
        idle(20);
        chk("single_bit_crc", last_crc[0], crc_ref(8, 32'h07, 32'hD8, 1024'd1, 1));

        // Random traffic with occasional resets; the per-cycle compare does the checking.
        for (int blk = 0; blk < 60; blk++) begin
            int p;
            p = $urandom_range(2, 9);
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                rst    = ($urandom_range(0, 299) == 0);
                active = ($urandom_range(0, 9) < p);
                data   = $urandom_range(0, 1);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        idle(30);
        for (int i = 0; i < NI; i++)
            chk($sformatf("msg_len_bound_u%0d", i), 32'(m_len[i] < 1024), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
